// File: rtl/multi_port_fifo.sv
// Multi-port show-ahead instruction queue: 0..WRITE_PORTS pushes and 0..READ_PORTS pops
// per cycle, all-or-nothing per side, with flush, halt and occupancy status.
module multi_port_fifo #(
  parameter int DATA_WIDTH         = 32,
  parameter int DEPTH              = 32,
  parameter int WRITE_PORTS        = 2,
  parameter int READ_PORTS         = 2,
  parameter int ALMOST_FULL_THRESH = DEPTH - 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                halt,
  input  logic                                flush,
  input  logic [$clog2(WRITE_PORTS+1)-1:0]    wr_num,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0]   din,
  output logic                                wr_accept,
  input  logic [$clog2(READ_PORTS+1)-1:0]     rd_num,
  output logic                                rd_accept,
  output logic [READ_PORTS*DATA_WIDTH-1:0]    dout,
  output logic [READ_PORTS-1:0]               dout_valid,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic [$clog2(DEPTH+1)-1:0]          free_slots,
  output logic                                empty,
  output logic                                full,
  output logic                                almost_full
);

  localparam int WN_W  = $clog2(WRITE_PORTS + 1);
  localparam int RN_W  = $clog2(READ_PORTS + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [WN_W-1:0]  WR_MAX    = WN_W'(WRITE_PORTS);
  localparam logic [RN_W-1:0]  RD_MAX    = RN_W'(READ_PORTS);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL  = CNT_W'(ALMOST_FULL_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      wr_add;
  logic [CNT_W-1:0]      rd_sub;

  // Both sides judge against the start-of-cycle count, so a pop never makes room for a same-cycle push.
  assign wr_accept = rst & ~halt & ~flush & (wr_num != '0) & (wr_num <= WR_MAX)
                   & (CNT_W'(wr_num) <= free_slots);
  assign rd_accept = rst & ~halt & ~flush & (rd_num != '0) & (rd_num <= RD_MAX)
                   & (CNT_W'(rd_num) <= count);

  assign wr_add = wr_accept ? CNT_W'(wr_num) : '0;
  assign rd_sub = rd_accept ? CNT_W'(rd_num) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (wr_accept) head <= head + PTR_W'(wr_num);
      if (rd_accept) tail <= tail + PTR_W'(rd_num);
      count <= count + wr_add - rd_sub;
    end
  end

  // Storage is not reset; stale entries are masked by dout_valid.
  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < WRITE_PORTS; k++) begin
      if (wr_accept && (WN_W'(k) < wr_num))
        mem[head + PTR_W'(k)] <= din[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    dout       = '0;
    dout_valid = '0;
    for (int unsigned k = 0; k < READ_PORTS; k++) begin
      dout[k*DATA_WIDTH +: DATA_WIDTH] = mem[tail + PTR_W'(k)];
      dout_valid[k]                    = count > CNT_W'(k);
    end
  end

  assign free_slots  = CNT_DEPTH - count;
  assign empty       = (count == '0);
  assign full        = (count == CNT_DEPTH);
  assign almost_full = (count >= AF_LEVEL);

endmodule
